// File: rtl/logic_unit_pkg.sv
// ============================================================================
// Module   : logic_unit_pkg
// Purpose  : Shared op encoding for the pipelined logic unit and its users.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_XNOR = 3'd4,
        OP_ANDN = 3'd5,
        OP_PASS = 3'd6,
        OP_XACC = 3'd7
    } logic_op_e;

endpackage : logic_unit_pkg

`default_nettype wire

// File: rtl/logic_unit_pipe_core.sv
// ============================================================================
// Module   : logic_core
// Purpose  : Combinational WIDTH-bit bitwise op mux; XACC folds as a ^ b.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (logic_op_e'(op))
            OP_AND:           result = a & b;
            OP_OR:            result = a | b;
            OP_XOR, OP_XACC:  result = a ^ b;
            OP_NOR:           result = ~(a | b);
            OP_XNOR:          result = ~(a ^ b);
            OP_ANDN:          result = a & ~b;
            OP_PASS:          result = a;
            default:          result = '0;
        endcase
    end

endmodule : logic_core

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Registered bitwise logic unit with valid/ready flow control and
//            an XOR-accumulate mode that folds a burst into one checksum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             acc_busy
);

    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_accum = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_core;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_in_ready;
    logic             w_fire;
    logic             w_is_xacc;
    logic             w_emit;

    logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (w_core)
    );

    // Accepting only when the output slot is free or draining keeps XACC
    // beats ordered behind any result still waiting for the consumer.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_fire     = in_valid && w_in_ready;
    assign w_is_xacc  = (logic_op_e'(in_op) == OP_XACC);
    assign w_emit     = w_fire && (!w_is_xacc || in_last);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_fire && w_is_xacc) begin
            w_state_nxt = in_last ? c_st_idle : c_st_accum;
        end
    end

    // State-derived outputs
    always_comb begin
        acc_busy = (r_state == c_st_accum);
    end

    // Accumulator and beat counter; non-XACC beats leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_fire && w_is_xacc) begin
            if (in_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= r_acc ^ w_core;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Output register: a new result overwrites a draining one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_is_xacc ? (r_acc ^ w_core) : w_core;
            r_out_count <= w_is_xacc ? w_cnt_inc : c_cnt_one;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_count  = r_out_count;
    assign out_parity = ^r_out_data;

endmodule : logic_unit_pipe

`default_nettype wire
